// File: rtl/dpram_fifo_ctrl_if.sv
// FIFO user/DPRAM-facing signal bundle for dpram_fifo_ctrl.
// master = environment (user logic + DPRAM), slave = the controller.
interface dpram_fifo_ctrl_if #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_SZ   = 4
) ();
  logic                 push;
  logic [RAM_WIDTH-1:0] push_data;
  logic                 pop;
  logic [RAM_WIDTH-1:0] pop_data;
  logic                 pop_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic [ADDR_SZ:0]     count;
  logic                 ready;
  logic                 flush;
  logic                 overflow;
  logic                 underflow;
  logic                 clr_err;
  logic [RAM_WIDTH-1:0] ram_data_in;
  logic [ADDR_SZ-1:0]   ram_wr_address;
  logic                 ram_write;
  logic [ADDR_SZ-1:0]   ram_rd_address;
  logic                 ram_read;
  logic [RAM_WIDTH-1:0] ram_data_out;

  modport master (
    output push, push_data, pop, flush, clr_err, ram_data_out,
    input  pop_data, pop_valid, full, empty, almost_full, count, ready,
           overflow, underflow, ram_data_in, ram_wr_address, ram_write,
           ram_rd_address, ram_read
  );

  modport slave (
    input  push, push_data, pop, flush, clr_err, ram_data_out,
    output pop_data, pop_valid, full, empty, almost_full, count, ready,
           overflow, underflow, ram_data_in, ram_wr_address, ram_write,
           ram_rd_address, ram_read
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM with 1-clk read latency.
// Sweeps the RAM with INIT_VALUE after reset, then runs as a FIFO.
module dpram_fifo_ctrl #(
  parameter int                   RAM_WIDTH  = 8,
  parameter int                   RAM_DEPTH  = 16,
  parameter int                   ADDR_SZ    = 4,
  parameter int                   AF_LEVEL   = 12,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic               clk,
  input logic               reset_n,
  dpram_fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_SZ:0] DEPTH_CNT = (ADDR_SZ+1)'(RAM_DEPTH);
  localparam logic [ADDR_SZ:0] AF_CNT    = (ADDR_SZ+1)'(AF_LEVEL);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             r_state, w_next_state;
  logic [ADDR_SZ-1:0] r_init_cnt, r_wr_ptr, r_rd_ptr;
  logic [ADDR_SZ:0]   r_count;
  logic               r_pop_valid, r_overflow, r_underflow;
  logic               w_run, w_full, w_empty, w_push_ok, w_pop_ok;

  assign w_run     = (r_state == ST_RUN);
  assign w_full    = (r_count == DEPTH_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = w_run && bus.push && !w_full  && !bus.flush;
  assign w_pop_ok  = w_run && bus.pop  && !w_empty && !bus.flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_INIT;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: if (&r_init_cnt) w_next_state = ST_RUN;
      ST_RUN:  w_next_state = ST_RUN;
    endcase
  end

  // NOTE: every output gets a default first so no path can infer a latch.
  // The INIT write is gated by reset_n so the RAM sees no write while held.
  always_comb begin
    bus.ram_write      = 1'b0;
    bus.ram_wr_address = '0;
    bus.ram_data_in    = '0;
    bus.ram_read       = 1'b0;
    bus.ram_rd_address = '0;
    case (r_state)
      ST_INIT: begin
        bus.ram_write      = reset_n;
        bus.ram_wr_address = r_init_cnt;
        bus.ram_data_in    = INIT_VALUE;
      end
      ST_RUN: begin
        bus.ram_write      = w_push_ok;
        bus.ram_wr_address = r_wr_ptr;
        bus.ram_data_in    = bus.push_data;
        bus.ram_read       = w_pop_ok;
        bus.ram_rd_address = r_rd_ptr;
      end
    endcase
  end

  // NOTE: the RAM array itself is never reset; the INIT sweep rewrites it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_init_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_ok;
      if (!w_run) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end else if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push_ok, w_pop_ok})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Sticky error flags: a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_run) begin
      if (bus.push && w_full)  r_overflow  <= 1'b1;
      else if (bus.clr_err)    r_overflow  <= 1'b0;
      if (bus.pop && w_empty)  r_underflow <= 1'b1;
      else if (bus.clr_err)    r_underflow <= 1'b0;
    end
  end

  assign bus.pop_data    = bus.ram_data_out;
  assign bus.pop_valid   = r_pop_valid;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = (r_count >= AF_CNT);
  assign bus.count       = r_count;
  assign bus.ready       = w_run;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: DPRAM model, FIFO reference model,
// and a scoreboard monitor comparing popped data as pop_valid appears.
module tb_dpram_fifo_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dpram_fifo_ctrl_if #(.RAM_WIDTH(8), .ADDR_SZ(4)) bus ();

  dpram_fifo_ctrl #(
    .RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_SZ(4), .AF_LEVEL(12), .INIT_VALUE(8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural DPRAM: write at the edge, registered read (1 clk latency).
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_wr_address] <= bus.ram_data_in;
    if (bus.ram_read)  bus.ram_data_out <= mem[bus.ram_rd_address];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  int m_wr = 0, m_rd = 0;
  bit m_ov = 0, m_un = 0;

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (reset_n && bus.pop_valid) begin
      if (exp_q.size() == 0) begin
        check("pop_valid_unexpected", 32'(bus.pop_valid), 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("pop_data", 32'(bus.pop_data), 32'(e));
      end
    end
  end

  task automatic step(input logic p, input logic [7:0] d, input logic q,
                      input logic f, input logic c);
    logic push_ok, pop_ok;
    int   mc;
    mc = model_q.size();
    bus.push = p; bus.push_data = d; bus.pop = q; bus.flush = f; bus.clr_err = c;
    push_ok = p && (mc < 16) && !f;
    pop_ok  = q && (mc > 0)  && !f;
    #1;
    check("ram_write", 32'(bus.ram_write), 32'(push_ok));
    if (push_ok) begin
      check("ram_wr_address", 32'(bus.ram_wr_address), 32'(m_wr));
      check("ram_data_in", 32'(bus.ram_data_in), 32'(d));
    end
    check("ram_read", 32'(bus.ram_read), 32'(pop_ok));
    if (pop_ok) check("ram_rd_address", 32'(bus.ram_rd_address), 32'(m_rd));
    if (p && mc == 16) m_ov = 1; else if (c) m_ov = 0;
    if (q && mc == 0)  m_un = 1; else if (c) m_un = 0;
    if (f) begin
      model_q.delete();
      m_wr = 0; m_rd = 0;
    end else begin
      if (pop_ok) begin
        exp_q.push_back(model_q.pop_front());
        m_rd = (m_rd + 1) % 16;
      end
      if (push_ok) begin
        model_q.push_back(d);
        m_wr = (m_wr + 1) % 16;
      end
    end
    mc = model_q.size();
    @(posedge clk); #1;
    bus.push = 0; bus.pop = 0; bus.flush = 0; bus.clr_err = 0;
    check("count", 32'(bus.count), 32'(mc));
    check("full", 32'(bus.full), 32'(mc == 16));
    check("empty", 32'(bus.empty), 32'(mc == 0));
    check("almost_full", 32'(bus.almost_full), 32'(mc >= 12));
    check("overflow", 32'(bus.overflow), 32'(m_ov));
    check("underflow", 32'(bus.underflow), 32'(m_un));
    check("pop_valid", 32'(bus.pop_valid), 32'(pop_ok));
  endtask

  task automatic do_init();
    for (int i = 0; i < 16; i++) begin
      check("init_ram_write", 32'(bus.ram_write), 32'd1);
      check("init_addr", 32'(bus.ram_wr_address), 32'(i));
      check("init_data", 32'(bus.ram_data_in), 32'h00);
      check("init_ready", 32'(bus.ready), 32'd0);
      @(posedge clk); #1;
    end
    check("ready_after_init", 32'(bus.ready), 32'd1);
    check("empty_after_init", 32'(bus.empty), 32'd1);
    check("ram_write_idle", 32'(bus.ram_write), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_almost_full", 32'(bus.almost_full), 32'd0);
    check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    check("rst_ram_write", 32'(bus.ram_write), 32'd0);
    check("rst_ram_read", 32'(bus.ram_read), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.push = 0; bus.push_data = 0; bus.pop = 0; bus.flush = 0; bus.clr_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset_n = 1'b1;
    #1;
    do_init();

    // Fill FF..F0, then a 17th push overflows
    for (int i = 0; i < 16; i++) step(1, 8'(8'hFF - i), 0, 0, 0);
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_full", 32'(bus.full), 32'd1);
    step(1, 8'hEE, 0, 0, 0);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_flag", 32'(bus.overflow), 32'd1);

    // Drain, extra pop underflows, clr_err clears both flags
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("drain_empty", 32'(bus.empty), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    check("unf_flag", 32'(bus.underflow), 32'd1);
    step(0, 8'h00, 0, 0, 1);
    check("clr_ovf", 32'(bus.overflow), 32'd0);
    check("clr_unf", 32'(bus.underflow), 32'd0);

    // Half full, push+pop every cycle across the pointer wrap
    for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(8'h20 + i), 1, 0, 0);
    check("half_count", 32'(bus.count), 32'd8);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Full with push+pop: only the pop is taken
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    step(1, 8'h99, 1, 0, 0);
    check("full_pp_count", 32'(bus.count), 32'd15);
    check("full_pp_ovf", 32'(bus.overflow), 32'd1);
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Empty with push+pop: only the push is taken
    step(1, 8'h77, 1, 0, 0);
    check("empty_pp_count", 32'(bus.count), 32'd1);
    check("empty_pp_unf", 32'(bus.underflow), 32'd1);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // Flush with 5 entries, concurrent pop must not produce pop_valid
    for (int i = 0; i < 5; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
    step(0, 8'h00, 1, 1, 0);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_pop_valid", 32'(bus.pop_valid), 32'd0);
    step(1, 8'h5A, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Asynchronous reset mid-traffic
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    bus.push = 1; bus.push_data = 8'hCC;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    bus.push = 0;
    model_q.delete();
    m_wr = 0; m_rd = 0; m_ov = 0; m_un = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    do_init();
    step(1, 8'h3C, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
